ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit: the AXI4-Lite read master directly upstream of the instruction memory slave. Takes one fetch request (PC) at a time from the core's next-PC logic, issues it on the AR channel, collects the R beat, and presents the instruction with its PC to the decode stage over a valid/ready handshake. Bus errors are reported as fetch faults. A flush input discards in-flight results.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value presented on `req_pc` is external; RESET_PC only seeds `inst_pc` at reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  fetch request valid.
- req_pc  in  32  fetch address.
- req_ready  out  1  block can accept a request.
- flush  in  1  discard current/pending fetch result.
- araddr  out  32  AR address.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready from instruction memory.
- rdata  in  32  read data.
- rresp  in  2  read response (0 = OKAY).
- rvalid  in  1  R valid.
- rready  out  1  R ready.
- inst_valid  out  1  instruction valid to decode.
- inst  out  32  fetched instruction.
- inst_pc  out  32  PC of `inst`.
- inst_fault  out  1  access fault (bus error or misalignment).
- inst_ready  in  1  decode accepts instruction.

## Operation
- FSM states: IDLE, ADDR, DATA, OUT.
- IDLE: `req_ready`=1. On `req_valid`: latch `req_pc` into pc register, go ADDR (or OUT with fault, see Configuration).
- ADDR: `arvalid`=1, `araddr`=latched PC, both stable until `arready`. On `arvalid&arready` go DATA.
- DATA: `rready`=1. On `rvalid`: capture `rdata` into `inst`, `inst_fault` = (`rresp`!=0), go OUT; if drop flag set, go IDLE instead and clear drop flag.
- OUT: `inst_valid`=1, `inst`/`inst_pc`/`inst_fault` held stable. On `inst_ready` go IDLE.
- Flush: in OUT → IDLE next cycle, `inst_valid` deasserts without handshake. In ADDR or DATA → set drop flag; AR is never withdrawn, transaction completes, R beat consumed and discarded. In IDLE → no effect; a `req_valid` in the same cycle as `flush` is still accepted.
- `inst_ready` and `flush` together in OUT: treated as flush (no difference in next state; decode must ignore).
- `rdata` with `inst_fault`=1: `inst` forced to 0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `arvalid`=0, `araddr`=0, `rready`=0, `inst_valid`=0, `inst`=0, `inst_pc`=RESET_PC, `inst_fault`=0, drop flag 0.
- Reset mid-transaction: all state returns to reset values immediately; no completion of outstanding AR/R (memory is reset by the same reset).
- Latency with zero-wait slave (arready=1, rvalid cycle after AR handshake): request accepted cycle 0, `arvalid` cycle 1, `rvalid` cycle 2, `inst_valid` cycle 3. Minimum 4 cycles per instruction (no overlap).
- All outputs registered or decoded from state only; no combinational path from `rvalid`/`arready` to outputs.
- Stall: `inst_valid` held indefinitely while `inst_ready`=0; no new request accepted.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined: in IDLE, a request with `req_pc[1:0]`!=0 skips the bus, goes straight to OUT next cycle with `inst_fault`=1, `inst`=0, `inst_pc`=req_pc.
- Not defined: no alignment check; `araddr` = `req_pc` unmodified, fault only from `rresp`.

## Structure
- Package `ifu_pkg`: FSM state enum (IDLE, ADDR, DATA, OUT), `RESP_OKAY` = 2'b00, default RESET_PC constant.
- Single module; no sub-module needed.

## Test plan
- Reset, single request pc=0x8000_0000, zero-wait slave returning 0x0000_0413 → `arvalid` cycle 1, `inst_valid` cycle 3 with inst=0x0000_0413, inst_pc=0x8000_0000, fault=0.
- Slave holds `arready`=0 for 3 cycles → `araddr`/`arvalid` stable throughout; `inst_valid` 3 cycles later than baseline.
- `inst_ready`=0 for 5 cycles in OUT → outputs stable, `req_ready`=0; after accept, new request taken next cycle.
- `flush` during DATA, rdata=0xDEAD_BEEF → R beat consumed, `inst_valid` never asserts, back to IDLE.
- `rresp`=2'b10 → `inst_fault`=1, inst=0.
- With `IFU_ALIGN_CHECK_EN`, pc=0x8000_0002 → no `arvalid`, `inst_valid` next cycle with fault=1; without it, `araddr`=0x8000_0002 issued.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    // Fetch FSM: accept request, drive AR, collect R, present to decode
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - request, AXI4-Lite read and decode-side signals of the fetch unit
interface ifu_fetch_if;
    // next-PC request
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        flush;
    // AXI4-Lite read address / data
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    // decode stage
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready;

    modport master (
        input  req_valid, req_pc, flush, arready, rdata, rresp, rvalid, inst_ready,
        output req_ready, araddr, arvalid, rready, inst_valid, inst, inst_pc, inst_fault
    );

    modport slave (
        output req_valid, req_pc, flush, arready, rdata, rresp, rvalid, inst_ready,
        input  req_ready, araddr, arvalid, rready, inst_valid, inst, inst_pc, inst_fault
    );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding AXI4-Lite instruction fetch unit (option: IFU_ALIGN_CHECK_EN)
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);

    ifu_state_e  r_state;
    ifu_state_e  w_state_nxt;
    logic        r_drop;
    logic        w_drop_nxt;
    logic [31:0] r_araddr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_fault;
    logic        w_accept;
    logic        w_misalign;
    logic        w_beat_keep;

`ifdef IFU_ALIGN_CHECK_EN
    assign w_misalign = (bus.req_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept    = (r_state == IDLE) && bus.req_valid;
    // An R beat is kept only if no flush arrived since the AR was issued
    assign w_beat_keep = (r_state == DATA) && bus.rvalid && !r_drop && !bus.flush;

    // State and drop flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Next-state logic; a flush during the bus phase lets the transaction finish but discards it
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = w_misalign ? OUT : ADDR;
                end
            end
            ADDR: begin
                if (bus.flush) begin
                    w_drop_nxt = 1'b1;
                end
                if (bus.arready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (bus.rvalid) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = (r_drop || bus.flush) ? IDLE : OUT;
                end else if (bus.flush) begin
                    w_drop_nxt = 1'b1;
                end
            end
            OUT: begin
                if (bus.flush || bus.inst_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_drop_nxt  = 1'b0;
            end
        endcase
    end

    // Address, instruction and fault capture; values only change outside the states that present them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_araddr  <= 32'h0;
            r_inst    <= 32'h0;
            r_inst_pc <= RESET_PC;
            r_fault   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_araddr  <= bus.req_pc;
                r_inst_pc <= bus.req_pc;
                if (w_misalign) begin
                    r_inst  <= 32'h0;
                    r_fault <= 1'b1;
                end
            end
            if (w_beat_keep) begin
                r_fault <= (bus.rresp != RESP_OKAY);
                r_inst  <= (bus.rresp != RESP_OKAY) ? 32'h0 : bus.rdata;
            end
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.arvalid    = (r_state == ADDR);
    assign bus.araddr     = r_araddr;
    assign bus.rready     = (r_state == DATA);
    assign bus.inst_valid = (r_state == OUT);
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.inst_fault = r_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   ticks;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ticks++;
    endtask

    // Present one request at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [31:0] pc);
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic ar_handshake();
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] data, input logic [1:0] resp);
        bus.rvalid = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        tick();
        bus.rvalid = 1'b0;
        bus.rresp  = 2'b00;
    endtask

    task automatic decode_accept();
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        n_tests = 0;
        n_fail  = 0;
        ticks   = 0;
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_pc     = 32'h0;
        bus.flush      = 1'b0;
        bus.arready    = 1'b0;
        bus.rdata      = 32'h0;
        bus.rresp      = 2'b00;
        bus.rvalid     = 1'b0;
        bus.inst_ready = 1'b0;

        // reset values
        tick(); tick();
        check("rst_req_ready",  bus.req_ready,  1);
        check("rst_arvalid",    bus.arvalid,    0);
        check("rst_araddr",     bus.araddr,     32'h0);
        check("rst_rready",     bus.rready,     0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst",       bus.inst,       32'h0);
        check("rst_inst_pc",    bus.inst_pc,    32'h8000_0000);
        check("rst_fault",      bus.inst_fault, 0);
        rst = 1'b1;
        tick();

        // baseline zero-wait fetch
        issue(32'h8000_0000);
        check("base_arvalid_c1", bus.arvalid,   1);
        check("base_araddr_c1",  bus.araddr,    32'h8000_0000);
        check("base_req_ready",  bus.req_ready, 0);
        ar_handshake();
        check("base_rready_c2",  bus.rready,    1);
        check("base_arvalid_c2", bus.arvalid,   0);
        r_beat(32'h0000_0413, 2'b00);
        check("base_valid_c3",   bus.inst_valid, 1);
        check("base_inst",       bus.inst,       32'h0000_0413);
        check("base_inst_pc",    bus.inst_pc,    32'h8000_0000);
        check("base_fault",      bus.inst_fault, 0);
        decode_accept();
        check("base_idle_valid", bus.inst_valid, 0);
        check("base_idle_ready", bus.req_ready,  1);

        // AR stalled three cycles
        t0 = ticks;
        issue(32'h8000_0004);
        for (int i = 0; i < 3; i++) begin
            check("arstall_arvalid", bus.arvalid, 1);
            check("arstall_araddr",  bus.araddr,  32'h8000_0004);
            tick();
        end
        ar_handshake();
        check("arstall_valid_early", bus.inst_valid, 0);
        r_beat(32'h0011_2233, 2'b00);
        check("arstall_valid",   bus.inst_valid, 1);
        check("arstall_latency", ticks - t0,     6);
        check("arstall_inst",    bus.inst,       32'h0011_2233);

        // decode stall for five cycles with a new request waiting
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h8000_0008;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",     bus.inst_valid, 1);
            check("stall_inst",      bus.inst,       32'h0011_2233);
            check("stall_inst_pc",   bus.inst_pc,    32'h8000_0004);
            check("stall_req_ready", bus.req_ready,  0);
            tick();
        end
        decode_accept();
        check("stall_post_valid", bus.inst_valid, 0);
        check("stall_post_ready", bus.req_ready,  1);
        tick();
        bus.req_valid = 1'b0;
        check("stall_next_arvalid", bus.arvalid, 1);
        check("stall_next_araddr",  bus.araddr,  32'h8000_0008);

        // error response forces inst to zero
        ar_handshake();
        r_beat(32'h1234_5678, 2'b10);
        check("err_valid",   bus.inst_valid, 1);
        check("err_fault",   bus.inst_fault, 1);
        check("err_inst",    bus.inst,       32'h0);
        check("err_inst_pc", bus.inst_pc,    32'h8000_0008);

        // flush while presenting
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_out_valid", bus.inst_valid, 0);
        check("flush_out_ready", bus.req_ready,  1);

        // flush coincident with the R beat
        issue(32'h8000_000C);
        ar_handshake();
        check("flush_data_rready", bus.rready, 1);
        bus.flush = 1'b1;
        r_beat(32'hDEAD_BEEF, 2'b00);
        bus.flush = 1'b0;
        check("flush_data_valid",  bus.inst_valid, 0);
        check("flush_data_ready",  bus.req_ready,  1);
        check("flush_data_rready0", bus.rready,    0);
        tick();
        check("flush_data_valid2", bus.inst_valid, 0);

        // flush during AR: AR held, R consumed later and discarded
        issue(32'h8000_0010);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_addr_arvalid", bus.arvalid, 1);
        check("flush_addr_araddr",  bus.araddr,  32'h8000_0010);
        ar_handshake();
        check("flush_addr_rready", bus.rready, 1);
        tick();
        check("flush_addr_rready2", bus.rready, 1);
        r_beat(32'hDEAD_BEEF, 2'b00);
        check("flush_addr_valid", bus.inst_valid, 0);
        check("flush_addr_ready", bus.req_ready,  1);

        // flush in IDLE does not block a request and leaves no drop pending
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h8000_0020;
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        check("idle_flush_arvalid", bus.arvalid, 1);
        check("idle_flush_araddr",  bus.araddr,  32'h8000_0020);
        ar_handshake();
        r_beat(32'h0000_0013, 2'b00);
        check("idle_flush_valid",   bus.inst_valid, 1);
        check("idle_flush_inst",    bus.inst,       32'h0000_0013);
        check("idle_flush_fault",   bus.inst_fault, 0);
        decode_accept();

        // misaligned PC
        issue(32'h8000_0002);
`ifdef IFU_ALIGN_CHECK_EN
        check("align_arvalid", bus.arvalid,    0);
        check("align_valid",   bus.inst_valid, 1);
        check("align_fault",   bus.inst_fault, 1);
        check("align_inst",    bus.inst,       32'h0);
        check("align_inst_pc", bus.inst_pc,    32'h8000_0002);
        decode_accept();
`else
        check("noalign_arvalid", bus.arvalid, 1);
        check("noalign_araddr",  bus.araddr,  32'h8000_0002);
        ar_handshake();
        r_beat(32'h0000_0093, 2'b00);
        check("noalign_valid", bus.inst_valid, 1);
        check("noalign_fault", bus.inst_fault, 0);
        check("noalign_inst",  bus.inst,       32'h0000_0093);
        decode_accept();
`endif

        // asynchronous reset mid-transaction
        issue(32'h8000_0030);
        check("arst_pre_arvalid", bus.arvalid, 1);
        #1 rst = 1'b0;
        #1;
        check("arst_arvalid",   bus.arvalid,   0);
        check("arst_araddr",    bus.araddr,    32'h0);
        check("arst_req_ready", bus.req_ready, 1);
        check("arst_inst_pc",   bus.inst_pc,   32'h8000_0000);
        check("arst_inst",      bus.inst,      32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("arst_post_idle", bus.req_ready, 1);
        check("arst_post_rready", bus.rready,  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
